// File: rtl/ranger_pkg.sv
// rtl/ranger_pkg.sv - shared state encoding and 100 MHz timing defaults for the echo ranger
package ranger_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    REPORT,
    HOLDOFF
  } state_e;

  localparam int unsigned DEF_CNT_W          = 32;
  localparam int unsigned DEF_TRIG_CYCLES    = 1000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 3800000;
  localparam int unsigned DEF_HOLDOFF_CYCLES = 6000000;

endpackage

// File: rtl/echo_sync_edge.sv
// rtl/echo_sync_edge.sv - 2-FF synchronizer with rise/fall pulses for an asynchronous sensor input
module echo_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Edges are taken between two settled stages so meta_q never drives logic.
  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/echo_ranger_ctrl.sv
// rtl/echo_ranger_ctrl.sv - ultrasonic ranging sequencer: trigger, echo timing, report, holdoff
module echo_ranger_ctrl
  import ranger_pkg::*;
#(
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             echo_in,
  output logic             trig,
  output logic             busy,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] meas_width,
  output logic             meas_timeout
);

  localparam logic [CNT_W-1:0] TRIG_N    = CNT_W'(TRIG_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_N = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] HOLDOFF_N = CNT_W'(HOLDOFF_CYCLES);

  state_e           state_q;
  logic [CNT_W-1:0] tmr_q;
  logic [CNT_W-1:0] width_q;
  logic             trig_q;
  logic             valid_q;
  logic             timeout_q;

  logic [CNT_W-1:0] tmr_d;
  logic [CNT_W-1:0] width_d;
  logic             echo_lvl;
  logic             echo_rise;
  logic             echo_fall;

  echo_sync_edge u_echo_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (echo_in),
    .level_o (echo_lvl),
    .rise_o  (echo_rise),
    .fall_o  (echo_fall)
  );

  assign tmr_d   = tmr_q + 1'b1;
  assign width_d = (&width_q) ? width_q : width_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      width_q   <= '0;
      trig_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tmr_q <= '0;
          if (start || continuous) begin
            state_q   <= TRIG;
            trig_q    <= 1'b1;
            width_q   <= '0;
            timeout_q <= 1'b0;
          end
        end
        TRIG: begin
          if (tmr_d == TRIG_N) begin
            state_q <= WAIT_RISE;
            trig_q  <= 1'b0;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_d;
          end
        end
        WAIT_RISE: begin
          tmr_q <= tmr_d;
          // Expiry beats a coincident rise: the timer compares with == and
          // would otherwise run past its limit inside MEASURE.
          if (tmr_d == TIMEOUT_N) begin
            state_q   <= REPORT;
            valid_q   <= 1'b1;
            timeout_q <= 1'b1;
            width_q   <= '0;
          end else if (echo_rise) begin
            state_q <= MEASURE;
            width_q <= CNT_W'(1);
          end
        end
        MEASURE: begin
          tmr_q <= tmr_d;
          if (echo_lvl) begin
            width_q <= width_d;
          end
          if (echo_fall) begin
            state_q <= REPORT;
            valid_q <= 1'b1;
          end else if (tmr_d == TIMEOUT_N) begin
            state_q   <= REPORT;
            valid_q   <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        REPORT: begin
          if (meas_ready) begin
            state_q <= HOLDOFF;
            valid_q <= 1'b0;
            tmr_q   <= '0;
          end
        end
        HOLDOFF: begin
          if (tmr_d == HOLDOFF_N) begin
            state_q <= IDLE;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_d;
          end
        end
        default: begin
          state_q <= IDLE;
          trig_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign trig         = trig_q;
  assign busy         = (state_q != IDLE);
  assign meas_valid   = valid_q;
  assign meas_width   = width_q;
  assign meas_timeout = timeout_q;

endmodule
